link_join_rx: RTL and testbench
===============================

Name: link_join_rx

Overview:
- Receive end of a split link between two distributed simulation partitions.
- Consumes the 32-bit word stream that the transport delivers for one link: 4-word frames carrying wen, token, clk_cnt and id.
- Validates each frame, buffers it in a small FIFO, and replays it on the local link as a one-cycle o_wen strobe with its token/clk_cnt/id.
- Replay happens only when the local cycle counter reaches the frame's clk_cnt, which keeps both partitions cycle-aligned.

Parameters:
- ID, 0: expected source id; frames with any other id are dropped.
- DEPTH, 4: FIFO entries (power of two, >=2).
- MAGIC, 16'hA5C3: required value of header bits [31:16].

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_rx_valid  in  1  transport word valid
- i_rx_data  in  32  transport word
- o_rx_ready  out  1  block accepts the word this cycle
- o_wen  out  1  one-cycle replay strobe
- o_token  out  32  token of the last replayed frame
- o_clk_cnt  out  32  clk_cnt of the last replayed frame
- o_id  out  32  id of the last replayed frame
- o_err_frame  out  1  one-cycle pulse: header magic mismatch
- o_err_id  out  1  one-cycle pulse: frame dropped, id != ID
- o_err_seq  out  1  one-cycle pulse: sequence gap
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset is i_rstn, synchronous, active-low; clock is i_clk. Reset applies at any time, including mid-frame and with the FIFO non-empty.
- Values forced in reset: all outputs 0 except o_rx_ready=1. Parser goes to HDR, FIFO is emptied, local_cnt=0, expected seq=0, and there is no first-frame flag.
- Word transfer: a word moves when i_rx_valid && o_rx_ready at a rising edge.
- Frame format:
  - W0 header: [31:16]=MAGIC, [15:8] reserved/ignored, [7:0]=seq.
  - W1 token.
  - W2 clk_cnt.
  - W3 id.
- Parser FSM, states HDR -> TOK -> CNT -> IDW -> HDR, advancing one state per transferred word.
- HDR:
  - Magic mismatch: word discarded, o_err_frame pulses the next cycle, parser stays in HDR.
  - Magic match: seq is captured. If seq != expected, o_err_seq pulses the next cycle; the frame is still processed.
  - In both cases expected is set to seq+1 (mod 256).
- TOK and CNT capture their words into holding registers.
- IDW:
  - id == ID: {token, clk_cnt, id} is written into the FIFO at the same edge.
  - id != ID: the frame is discarded, o_err_id pulses the next cycle, and no FIFO write occurs.
- o_rx_ready is 1 in HDR, TOK and CNT.
- In IDW, o_rx_ready = !full || pop_now, where pop_now is the registered-head release decision of the current cycle. There is no combinational path from i_rx_* to o_rx_ready.
- Local counter: local_cnt is 0 in the first cycle after reset release, increments by 1 every cycle, and wraps at 2^32.
- Release:
  - pop_now = !empty && $signed(local_cnt - head.clk_cnt) >= 0. The 32-bit signed difference makes the comparison wrap-safe.
  - At most one pop per cycle.
  - On a pop, o_wen=1 in the next cycle, and o_token/o_clk_cnt/o_id load the head values and hold until the next pop. Otherwise o_wen=0.
- Latency: an IDW handshake at edge t puts the entry at the head in cycle t+1. The earliest o_wen is cycle t+2, taken when head.clk_cnt <= local_cnt in cycle t+1.
- Late frames (clk_cnt already passed) release at the earliest opportunity and are not flagged.
- Full FIFO: a simultaneous push and pop is allowed and o_level is unchanged. Full with no pop stalls in IDW and no word is lost.
- Empty FIFO: no pop and o_wen=0. A push into an empty FIFO is not bypassed.
- o_level is registered and equals the number of stored entries.

Test Plan:
1. Basic replay: reset, then send {A5C3_0000, 0000_1234, 20, 0} back-to-back from cycle 0. Required: o_wen high exactly once, in cycle 21; o_token=0x1234, o_clk_cnt=20, o_id=0 held afterwards; no error pulses.
2. Bad magic then good frame: send header 0xDEAD0000, then a valid seq-0 frame with clk_cnt=5. Required: one o_err_frame pulse; the valid frame still replays; o_err_seq stays 0.
3. Id filter with ID=0: send a frame with id=3 and seq 0, then a frame with id=0 and seq 1. Required: one o_err_id pulse; exactly one o_wen; o_level peaks at 1.
4. Sequence gap: send seq 0 then seq 2. Required: one o_err_seq pulse on the second header; both frames replay in clk_cnt order.
5. Full/backpressure with DEPTH=4: send 6 frames with clk_cnt=100. Required: o_rx_ready low in IDW of the 5th frame until cycle 100; o_level=4 while stalled; 6 o_wen pulses on consecutive cycles from cycle 101 (plus the parse delay of frames 5–6); no loss.
6. Reset mid-operation and wrap: assert reset during TOK with 2 entries queued. Required: o_level=0, no o_wen, and the next HDR is parsed cleanly. Separately, force local_cnt near 0xFFFF_FFF0 with clk_cnt=0x0000_0002: o_wen is emitted after the wrap, not immediately.

Source files
------------

// File: rtl/link_join_rx.sv
// Receive end of a split link: parses 4-word frames from the transport, queues them,
// and replays each one when the local cycle counter reaches the frame's clk_cnt.
module link_join_rx #(
    parameter logic [31:0] ID    = 32'd0,
    parameter int          DEPTH = 4,
    parameter logic [15:0] MAGIC = 16'hA5C3
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_rx_valid,
    input  logic [31:0]              i_rx_data,
    output logic                     o_rx_ready,
    output logic                     o_wen,
    output logic [31:0]              o_token,
    output logic [31:0]              o_clk_cnt,
    output logic [31:0]              o_id,
    output logic                     o_err_frame,
    output logic                     o_err_id,
    output logic                     o_err_seq,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {HDR, TOK, CNT, IDW} state_t;

    state_t        state_q, state_d;
    logic [7:0]    exp_seq_q, exp_seq_d;
    logic [31:0]   tok_q, tok_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   local_cnt_q, local_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wen_q, wen_d;
    logic [31:0]   token_q, token_d;
    logic [31:0]   clk_cnt_q, clk_cnt_d;
    logic [31:0]   id_q, id_d;
    logic          err_frame_q, err_frame_d;
    logic          err_id_q, err_id_d;
    logic          err_seq_q, err_seq_d;

    logic [31:0]   mem_tok_q [DEPTH];
    logic [31:0]   mem_cnt_q [DEPTH];

    logic          empty, full, pop_now, push, rx_ready, xfer;
    logic [31:0]   head_cnt, cnt_diff;

    always_comb begin
        state_d     = state_q;
        exp_seq_d   = exp_seq_q;
        tok_d       = tok_q;
        cnt_d       = cnt_q;
        local_cnt_d = local_cnt_q + 32'd1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        wen_d       = 1'b0;
        token_d     = token_q;
        clk_cnt_d   = clk_cnt_q;
        id_d        = id_q;
        err_frame_d = 1'b0;
        err_id_d    = 1'b0;
        err_seq_d   = 1'b0;
        push        = 1'b0;

        // Signed difference keeps the release test correct across counter wrap.
        head_cnt = mem_cnt_q[rd_ptr_q];
        cnt_diff = local_cnt_q - head_cnt;
        empty    = (level_q == '0);
        full     = (level_q == (AW+1)'(DEPTH));
        pop_now  = !empty && !cnt_diff[31];
        rx_ready = (state_q != IDW) || !full || pop_now;
        xfer     = i_rx_valid && rx_ready;

        if (xfer) begin
            unique case (state_q)
                HDR: begin
                    if (i_rx_data[31:16] == MAGIC) begin
                        err_seq_d = (i_rx_data[7:0] != exp_seq_q);
                        exp_seq_d = i_rx_data[7:0] + 8'd1;
                        state_d   = TOK;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                TOK: begin
                    tok_d   = i_rx_data;
                    state_d = CNT;
                end
                CNT: begin
                    cnt_d   = i_rx_data;
                    state_d = IDW;
                end
                IDW: begin
                    state_d = HDR;
                    if (i_rx_data == ID) push = 1'b1;
                    else                 err_id_d = 1'b1;
                end
                default: state_d = HDR;
            endcase
        end

        if (pop_now) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            wen_d     = 1'b1;
            token_d   = mem_tok_q[rd_ptr_q];
            clk_cnt_d = head_cnt;
            id_d      = ID;
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push, pop_now})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= HDR;
            exp_seq_q   <= '0;
            tok_q       <= '0;
            cnt_q       <= '0;
            local_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wen_q       <= 1'b0;
            token_q     <= '0;
            clk_cnt_q   <= '0;
            id_q        <= '0;
            err_frame_q <= 1'b0;
            err_id_q    <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_seq_q   <= exp_seq_d;
            tok_q       <= tok_d;
            cnt_q       <= cnt_d;
            local_cnt_q <= local_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wen_q       <= wen_d;
            token_q     <= token_d;
            clk_cnt_q   <= clk_cnt_d;
            id_q        <= id_d;
            err_frame_q <= err_frame_d;
            err_id_q    <= err_id_d;
            err_seq_q   <= err_seq_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_tok_q[wr_ptr_q] <= tok_q;
            mem_cnt_q[wr_ptr_q] <= cnt_q;
        end
    end

    assign o_rx_ready  = rx_ready;
    assign o_wen       = wen_q;
    assign o_token     = token_q;
    assign o_clk_cnt   = clk_cnt_q;
    assign o_id        = id_q;
    assign o_err_frame = err_frame_q;
    assign o_err_id    = err_id_q;
    assign o_err_seq   = err_seq_q;
    assign o_level     = level_q;

endmodule

// File: tb/tb_link_join_rx.sv
// Directed bench for link_join_rx: a table of single-frame cases plus hand-written
// sequences for bad magic, id filtering, sequence gaps, backpressure and mid-frame reset.
module tb_link_join_rx;

    logic        clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [31:0] i_rx_data = '0;
    logic        o_rx_ready, o_wen, o_err_frame, o_err_id, o_err_seq;
    logic [31:0] o_token, o_clk_cnt, o_id;
    logic [2:0]  o_level;

    link_join_rx #(.ID(32'd0), .DEPTH(4), .MAGIC(16'hA5C3)) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_rx_ready(o_rx_ready), .o_wen(o_wen), .o_token(o_token), .o_clk_cnt(o_clk_cnt),
        .o_id(o_id), .o_err_frame(o_err_frame), .o_err_id(o_err_id), .o_err_seq(o_err_seq),
        .o_level(o_level)
    );

    always #5 clk = ~clk;

    // Cycle number as seen by the design: 0 in the first cycle after reset release.
    logic [31:0] cyc = '0;
    always @(posedge clk) begin
        if (!i_rstn) cyc <= '0;
        else         cyc <= cyc + 32'd1;
    end

    int          vectorsApplied = 0;
    int          miscompares = 0;
    int          wenCyc[$];
    logic [31:0] wenTok[$];
    logic [31:0] wenCnt[$];
    int          errFrameN, errIdN, errSeqN, levelMax, stallN, lastStall, stallBadLevel;

    always @(negedge clk) begin
        if (i_rstn) begin
            if (o_wen) begin
                wenCyc.push_back(int'(cyc));
                wenTok.push_back(o_token);
                wenCnt.push_back(o_clk_cnt);
            end
            if (o_err_frame) errFrameN++;
            if (o_err_id) errIdN++;
            if (o_err_seq) errSeqN++;
            if (int'(o_level) > levelMax) levelMax = int'(o_level);
            if (!o_rx_ready) begin
                stallN++;
                lastStall = int'(cyc);
                if (o_level != 3'd4) stallBadLevel++;
            end
        end
    end

    typedef struct {
        string       name;
        logic [31:0] hdr, tok, cnt, id;
        int          expWens, expWenCycle, expErrFrame, expErrId, expErrSeq, expLevel;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic doReset();
        i_rstn = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data = '0;
        @(posedge clk);
        #1;
        wenCyc.delete(); wenTok.delete(); wenCnt.delete();
        errFrameN = 0; errIdN = 0; errSeqN = 0; levelMax = 0;
        stallN = 0; lastStall = -1; stallBadLevel = 0;
        @(posedge clk);
        @(negedge clk);
        i_rstn = 1'b1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        i_rx_valid = 1'b1;
        i_rx_data = w;
        while (!o_rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_rx_ready) checkOutput("sendTimeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] hdr, tok, cnt, id);
        sendWord(hdr);
        sendWord(tok);
        sendWord(cnt);
        sendWord(id);
    endtask

    task automatic waitCycle(input int c);
        while (int'(cyc) < c) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ready"}, 32'(o_rx_ready), 32'd1);
        checkOutput({tag, ".wen"}, 32'(o_wen), 32'd0);
        checkOutput({tag, ".level"}, 32'(o_level), 32'd0);
        checkOutput({tag, ".token"}, o_token, 32'd0);
        checkOutput({tag, ".clkcnt"}, o_clk_cnt, 32'd0);
        checkOutput({tag, ".id"}, o_id, 32'd0);
        checkOutput({tag, ".errs"}, {29'd0, o_err_frame, o_err_id, o_err_seq}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] expTok, expCnt;
        doReset();
        sendFrame(v.hdr, v.tok, v.cnt, v.id);
        waitCycle(45);
        expTok = (v.expWens == 1) ? v.tok : 32'd0;
        expCnt = (v.expWens == 1) ? v.cnt : 32'd0;
        checkOutput({v.name, ".wens"}, 32'(wenCyc.size()), 32'(v.expWens));
        if (v.expWens == 1 && wenCyc.size() > 0)
            checkOutput({v.name, ".wenCycle"}, 32'(wenCyc[0]), 32'(v.expWenCycle));
        checkOutput({v.name, ".token"}, o_token, expTok);
        checkOutput({v.name, ".clkcnt"}, o_clk_cnt, expCnt);
        checkOutput({v.name, ".id"}, o_id, 32'd0);
        checkOutput({v.name, ".errFrame"}, 32'(errFrameN), 32'(v.expErrFrame));
        checkOutput({v.name, ".errId"}, 32'(errIdN), 32'(v.expErrId));
        checkOutput({v.name, ".errSeq"}, 32'(errSeqN), 32'(v.expErrSeq));
        checkOutput({v.name, ".level"}, 32'(o_level), 32'(v.expLevel));
    endtask

    initial begin
        //                name       hdr           tok           cnt           id     wens cyc fr id sq lvl
        vecs[0] = '{"basic",   32'hA5C3_0000, 32'h0000_1234, 32'd20,        32'd0, 1, 21, 0, 0, 0, 0};
        vecs[1] = '{"badId",   32'hA5C3_0000, 32'h0000_0BAD, 32'd20,        32'd3, 0, 0,  0, 1, 0, 0};
        vecs[2] = '{"seqGap",  32'hA5C3_0005, 32'h0000_0077, 32'd10,        32'd0, 1, 11, 0, 0, 1, 0};
        vecs[3] = '{"late",    32'hA5C3_0000, 32'h0000_0042, 32'd0,         32'd0, 1, 5,  0, 0, 0, 0};
        vecs[4] = '{"rsvd",    32'hA5C3_FF00, 32'h0000_0099, 32'd7,         32'd0, 1, 8,  0, 0, 0, 0};
        vecs[5] = '{"wrapOld", 32'hA5C3_0000, 32'h0000_00AA, 32'hFFFF_FFF0, 32'd0, 1, 5,  0, 0, 0, 0};
        vecs[6] = '{"farFut",  32'hA5C3_0000, 32'h0000_00BB, 32'h7FFF_FFF0, 32'd0, 0, 0,  0, 0, 0, 1};
        vecs[7] = '{"minLat",  32'hA5C3_0000, 32'h0000_00CC, 32'd4,         32'd0, 1, 5,  0, 0, 0, 0};

        doReset();
        checkResetState("reset");

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Bad magic header is discarded, the following good frame is unaffected.
        doReset();
        sendWord(32'hDEAD_0000);
        sendFrame(32'hA5C3_0000, 32'h0000_0055, 32'd5, 32'd0);
        waitCycle(20);
        checkOutput("badMagic.errFrame", 32'(errFrameN), 32'd1);
        checkOutput("badMagic.errSeq", 32'(errSeqN), 32'd0);
        checkOutput("badMagic.wens", 32'(wenCyc.size()), 32'd1);
        if (wenCyc.size() > 0) checkOutput("badMagic.wenCycle", 32'(wenCyc[0]), 32'd6);
        checkOutput("badMagic.token", o_token, 32'h55);

        // Dropped id followed by an accepted frame.
        doReset();
        sendFrame(32'hA5C3_0000, 32'h0000_0111, 32'd30, 32'd3);
        sendFrame(32'hA5C3_0001, 32'h0000_0222, 32'd30, 32'd0);
        waitCycle(40);
        checkOutput("idFilter.errId", 32'(errIdN), 32'd1);
        checkOutput("idFilter.errSeq", 32'(errSeqN), 32'd0);
        checkOutput("idFilter.wens", 32'(wenCyc.size()), 32'd1);
        checkOutput("idFilter.levelMax", 32'(levelMax), 32'd1);
        checkOutput("idFilter.token", o_token, 32'h222);

        // Sequence gap: second frame flagged but still replayed in order.
        doReset();
        sendFrame(32'hA5C3_0000, 32'h0000_000A, 32'd12, 32'd0);
        sendFrame(32'hA5C3_0002, 32'h0000_000B, 32'd40, 32'd0);
        waitCycle(50);
        checkOutput("seqPair.errSeq", 32'(errSeqN), 32'd1);
        checkOutput("seqPair.wens", 32'(wenCyc.size()), 32'd2);
        if (wenCyc.size() == 2) begin
            checkOutput("seqPair.cyc0", 32'(wenCyc[0]), 32'd13);
            checkOutput("seqPair.cyc1", 32'(wenCyc[1]), 32'd41);
            checkOutput("seqPair.tok0", wenTok[0], 32'hA);
            checkOutput("seqPair.tok1", wenTok[1], 32'hB);
        end

        // Six frames into a four-entry FIFO, all due at cycle 100.
        doReset();
        for (int k = 0; k < 6; k++)
            sendFrame(32'hA5C3_0000 | 32'(k), 32'(k + 1), 32'd100, 32'd0);
        waitCycle(115);
        checkOutput("full.wens", 32'(wenCyc.size()), 32'd6);
        checkOutput("full.levelMax", 32'(levelMax), 32'd4);
        checkOutput("full.stallCycles", 32'(stallN), 32'd81);
        checkOutput("full.lastStall", 32'(lastStall), 32'd99);
        checkOutput("full.stallLevel", 32'(stallBadLevel), 32'd0);
        checkOutput("full.errSeq", 32'(errSeqN), 32'd0);
        for (int k = 0; k < 6 && k < wenCyc.size(); k++) begin
            checkOutput($sformatf("full.cyc%0d", k), 32'(wenCyc[k]), 32'(101 + k));
            checkOutput($sformatf("full.tok%0d", k), wenTok[k], 32'(k + 1));
            checkOutput($sformatf("full.cnt%0d", k), wenCnt[k], 32'd100);
        end
        checkOutput("full.levelEnd", 32'(o_level), 32'd0);

        // Reset in TOK with two entries queued, then a clean frame.
        doReset();
        sendFrame(32'hA5C3_0000, 32'h1, 32'd1000, 32'd0);
        sendFrame(32'hA5C3_0001, 32'h2, 32'd1000, 32'd0);
        sendWord(32'hA5C3_0002);
        checkOutput("midReset.levelBefore", 32'(o_level), 32'd2);
        doReset();
        checkResetState("midReset");
        waitCycle(30);
        checkOutput("midReset.wens", 32'(wenCyc.size()), 32'd0);
        checkOutput("midReset.level", 32'(o_level), 32'd0);
        sendFrame(32'hA5C3_0000, 32'h0000_0066, 32'd40, 32'd0);
        waitCycle(50);
        checkOutput("midReset.cleanWens", 32'(wenCyc.size()), 32'd1);
        if (wenCyc.size() > 0) checkOutput("midReset.cleanCycle", 32'(wenCyc[0]), 32'd41);
        checkOutput("midReset.errs", 32'(errFrameN + errIdN + errSeqN), 32'd0);
        checkOutput("midReset.token", o_token, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
